spi_usb_arbiter: RTL

- Shares the single SPI0 master port (SS_n/SCLK/MOSI/MISO) between two on-chip requesters.
  - Requester 0: USB host register access.
  - Requester 1: keycode poller / debug.
- The shared port drives the USB host controller on the Arduino shield.
- Grants are round-robin per transaction, one transaction being a multi-byte chip-select frame; each byte is serialised MSB-first in SPI mode 0.
- Sits between the requesters and the ARDUINO_IO SPI pins in the top level.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 38 +++
 rtl/spi_usb_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg
// Shared types and constants for the SPI0 arbiter and its clock divider.
//   spi_state_t   : arbiter FSM states
//   BITS_PER_BYTE : bits serialised per SPI byte
//   spi_byte_t    : one SPI data byte
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        LOAD,
        LOW,
        HIGH,
        GAP
    } spi_state_t;

    localparam int BITS_PER_BYTE = 8;

    typedef logic [7:0] spi_byte_t;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div
// Free-running modulo-CLK_DIV counter that marks SCLK half-period boundaries.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   clr_i  : synchronous clear, holds the count at zero while high
//   tick_o : high on the terminal count (CLK_DIV-1)
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] TC = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick_o = (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || tick_o) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_usb_arbiter.sv
// spi_usb_arbiter
// Shares one SPI mode-0 master port between two requesters (0: USB host
// register access, 1: keycode poller/debug). Ownership is granted round-robin
// per chip-select frame; each frame carries one or more bytes, MSB first.
//   Clk, Reset_h        : system clock, asynchronous active-high reset
//   req/valid/last[1:0] : per-requester frame request, byte present, final byte
//   tx_data0/tx_data1   : per-requester transmit byte
//   gnt                 : one-hot owner, held for the whole frame
//   ready               : owner's byte accepted this cycle
//   rx_data/rx_valid    : received byte and its one-cycle strobe
//   busy                : FSM not idle
//   SPI_SS_n/SCLK/MOSI  : SPI master outputs, SPI_MISO : SPI master input
module spi_usb_arbiter
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       Clk,
    input  logic       Reset_h,
    input  logic [1:0] req,
    input  logic [1:0] valid,
    input  logic [1:0] last,
    input  spi_byte_t  tx_data0,
    input  spi_byte_t  tx_data1,
    output logic [1:0] gnt,
    output logic       ready,
    output spi_byte_t  rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       SPI_SS_n,
    output logic       SPI_SCLK,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO
);

    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);
    localparam logic [3:0] GAP_TC   = 4'(CS_GAP - 1);

    spi_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       rr_q, rr_d;
    logic [1:0] gnt_q, gnt_d;
    logic       ss_n_q, ss_n_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    spi_byte_t  tx_sh_q, tx_sh_d;
    spi_byte_t  rx_sh_q, rx_sh_d;
    spi_byte_t  rx_data_q, rx_data_d;
    logic       last_q, last_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;

    logic       tick;
    logic       div_clr;
    logic       ready_c;
    logic       rx_valid_c;
    logic       go_gap;
    logic       pick;

    // Only the owner's handshake is ever looked at.
    logic       own_req;
    logic       own_valid;
    logic       own_last;
    spi_byte_t  own_tx;

    assign own_req   = req[owner_q];
    assign own_valid = valid[owner_q];
    assign own_last  = last[owner_q];
    assign own_tx    = owner_q ? tx_data1 : tx_data0;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk_i (Clk),
        .rst_i (Reset_h),
        .clr_i (div_clr),
        .tick_o(tick)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        ss_n_d     = ss_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        last_d     = last_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        div_clr    = 1'b0;
        ready_c    = 1'b0;
        rx_valid_c = 1'b0;
        go_gap     = 1'b0;
        pick       = rr_q;

        case (state_q)
            IDLE: begin
                div_clr = 1'b1;
                if (|req) begin
                    // Pointer side wins a tie; otherwise the lone requester.
                    pick    = req[rr_q] ? rr_q : ~rr_q;
                    owner_d = pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    ss_n_d  = 1'b0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Divider held at zero so LOW always lasts a full half-period.
                div_clr = 1'b1;
                if (own_valid) begin
                    ready_c   = 1'b1;
                    tx_sh_d   = own_tx;
                    last_d    = own_last;
                    mosi_d    = own_tx[7];
                    bit_cnt_d = 3'd0;
                    state_d   = LOW;
                end else if (!own_req) begin
                    go_gap = 1'b1;
                end
            end
            LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], SPI_MISO};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_valid_c = 1'b1;
                        rx_data_d  = rx_sh_q;
                        if (last_q) begin
                            go_gap = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        mosi_d  = tx_sh_q[6];
                        state_d = LOW;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_cnt_q == GAP_TC) begin
                        gap_cnt_d = 4'd0;
                        state_d   = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame end, completed or aborted: release the port and hand
        // priority to the other requester.
        if (go_gap) begin
            state_d   = GAP;
            ss_n_d    = 1'b1;
            gnt_d     = 2'b00;
            mosi_d    = 1'b0;
            rr_d      = ~owner_q;
            gap_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_q      <= 1'b0;
            gnt_q     <= 2'b00;
            ss_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            last_q    <= 1'b0;
            bit_cnt_q <= 3'd0;
            gap_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            ss_n_q    <= ss_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            last_q    <= last_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // The completed byte is shown in its strobe cycle, then held registered.
    assign rx_data  = rx_valid_c ? rx_sh_q : rx_data_q;
    assign rx_valid = rx_valid_c;
    assign ready    = ready_c;
    assign gnt      = gnt_q;
    assign busy     = (state_q != IDLE);
    assign SPI_SS_n = ss_n_q;
    assign SPI_SCLK = sclk_q;
    assign SPI_MOSI = mosi_q;

endmodule
